// File: rtl/pipe_ex_stage.sv
// Execute stage with MEM/WB forwarding, load-use bubble insertion, an iterative
// shift-add multiplier and the EX/MEM pipeline register.
module pipe_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ex_valid,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic             ex_wmem,
  input  logic [3:0]       ex_aluc,
  input  logic             ex_shift,
  input  logic             ex_aluimm,
  input  logic [REGW-1:0]  ex_rs,
  input  logic [REGW-1:0]  ex_rt,
  input  logic [REGW-1:0]  ex_wn,
  input  logic [WIDTH-1:0] ex_qa,
  input  logic [WIDTH-1:0] ex_qb,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic             wb_wreg,
  input  logic [REGW-1:0]  wb_wn,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_stall,
  output logic             mem_valid,
  output logic             mem_wreg,
  output logic             mem_m2reg,
  output logic             mem_wmem,
  output logic [REGW-1:0]  mem_wn,
  output logic [WIDTH-1:0] mem_alu,
  output logic [WIDTH-1:0] mem_di,
  output logic             mem_z
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_wreg_q, mem_wreg_d;
  logic              mem_m2reg_q, mem_m2reg_d;
  logic              mem_wmem_q, mem_wmem_d;
  logic [REGW-1:0]   mem_wn_q, mem_wn_d;
  logic [WIDTH-1:0]  mem_alu_q, mem_alu_d;
  logic [WIDTH-1:0]  mem_di_q, mem_di_d;
  logic              mem_z_q, mem_z_d;

  logic [WIDTH-1:0]  fa, fb, alua, alub, alu_r;
  logic [SHW-1:0]    sh;
  logic              mem_fwd_ok, wb_fwd_ok, hazard, mul_start, stall_c;

  // Operand forwarding: MEM beats WB beats register file; r0 never forwarded.
  always_comb begin
    mem_fwd_ok = mem_valid_q & mem_wreg_q & ~mem_m2reg_q & (mem_wn_q != '0);
    wb_fwd_ok  = wb_wreg & (wb_wn != '0);
    if (mem_fwd_ok && (mem_wn_q == ex_rs))   fa = mem_alu_q;
    else if (wb_fwd_ok && (wb_wn == ex_rs))  fa = wb_data;
    else                                     fa = ex_qa;
    if (mem_fwd_ok && (mem_wn_q == ex_rt))   fb = mem_alu_q;
    else if (wb_fwd_ok && (wb_wn == ex_rt))  fb = wb_data;
    else                                     fb = ex_qb;
    alua = ex_shift  ? ex_imm : fa;
    alub = ex_aluimm ? ex_imm : fb;
    sh   = alua[SHW-1:0];
  end

  // Load-use detection against a load sitting in MEM.
  always_comb begin
    hazard = ex_valid & mem_valid_q & mem_m2reg_q & mem_wreg_q & (mem_wn_q != '0) &
             ((~ex_shift & (mem_wn_q == ex_rs)) |
              ((~ex_aluimm | ex_wmem) & (mem_wn_q == ex_rt)));
    mul_start = ex_valid & (ex_aluc == 4'd10) & ~hazard;
  end

  // Single-cycle ALU; multiply results come from the iterative unit instead.
  always_comb begin
    alu_r = '0;
    case (ex_aluc)
      4'd0: alu_r = alua + alub;
      4'd1: alu_r = alua - alub;
      4'd2: alu_r = alua & alub;
      4'd3: alu_r = alua | alub;
      4'd4: alu_r = alua ^ alub;
      4'd5: alu_r = alub << (WIDTH / 2);
      4'd6: alu_r = alub << sh;
      4'd7: alu_r = alub >> sh;
      4'd8: alu_r = $signed(alub) >>> sh;
      4'd9: alu_r = {{(WIDTH-1){1'b0}}, ($signed(alua) < $signed(alub))};
      default: alu_r = '0;
    endcase
  end

  // Multiplier FSM and EX/MEM next-state; bubbles by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    stall_c     = 1'b0;
    mem_valid_d = 1'b0;
    mem_wreg_d  = 1'b0;
    mem_m2reg_d = 1'b0;
    mem_wmem_d  = 1'b0;
    mem_wn_d    = ex_wn;
    mem_alu_d   = alu_r;
    mem_di_d    = fb;
    mem_z_d     = (alu_r == '0);
    case (state_q)
      S_IDLE: begin
        if (hazard) begin
          stall_c = 1'b1;
        end else if (mul_start) begin
          stall_c  = 1'b1;
          mcand_d  = alua;
          mplier_d = alub;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          mem_valid_d = ex_valid;
          mem_wreg_d  = ex_valid & ex_wreg;
          mem_m2reg_d = ex_valid & ex_m2reg;
          mem_wmem_d  = ex_valid & ex_wmem;
        end
      end
      S_MUL: begin
        stall_c = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        mem_valid_d = ex_valid;
        mem_wreg_d  = ex_valid & ex_wreg;
        mem_m2reg_d = ex_valid & ex_m2reg;
        mem_wmem_d  = ex_valid & ex_wmem;
        mem_alu_d   = acc_q;
        mem_z_d     = (acc_q == '0);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is held low during reset so upstream is never frozen by stale state.
  assign ex_stall = clrn & stall_c;

  // State and pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
      mem_wmem_q  <= 1'b0;
      mem_wn_q    <= '0;
      mem_alu_q   <= '0;
      mem_di_q    <= '0;
      mem_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mem_valid_q <= mem_valid_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_m2reg_q <= mem_m2reg_d;
      mem_wmem_q  <= mem_wmem_d;
      mem_wn_q    <= mem_wn_d;
      mem_alu_q   <= mem_alu_d;
      mem_di_q    <= mem_di_d;
      mem_z_q     <= mem_z_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_m2reg = mem_m2reg_q;
  assign mem_wmem  = mem_wmem_q;
  assign mem_wn    = mem_wn_q;
  assign mem_alu   = mem_alu_q;
  assign mem_di    = mem_di_q;
  assign mem_z     = mem_z_q;

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Directed bench for pipe_ex_stage: ALU vector table plus hand-written
// forwarding, load-use, multiply and reset sequences.
module tb_pipe_ex_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_shift, ex_aluimm;
  logic [3:0]  ex_aluc;
  logic [4:0]  ex_rs, ex_rt, ex_wn, wb_wn;
  logic [31:0] ex_qa, ex_qb, ex_imm, wb_data;
  logic        wb_wreg;
  logic        ex_stall, mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_z;
  logic [4:0]  mem_wn;
  logic [31:0] mem_alu, mem_di;

  int total = 0;
  int bad   = 0;

  pipe_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .clrn(clrn), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_aluc(ex_aluc),
    .ex_shift(ex_shift), .ex_aluimm(ex_aluimm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wn(ex_wn), .ex_qa(ex_qa), .ex_qb(ex_qb), .ex_imm(ex_imm),
    .wb_wreg(wb_wreg), .wb_wn(wb_wn), .wb_data(wb_data), .ex_stall(ex_stall),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_wmem(mem_wmem), .mem_wn(mem_wn), .mem_alu(mem_alu), .mem_di(mem_di),
    .mem_z(mem_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aluc;
    logic        shift;
    logic        aluimm;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [31:0] exp_alu;
    logic        exp_z;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] aluc, input logic sh, input logic ai,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wn,
                       input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm,
                       input logic wreg, input logic m2reg, input logic wmem);
    ex_valid = 1'b1; ex_aluc = aluc; ex_shift = sh; ex_aluimm = ai;
    ex_rs = rs; ex_rt = rt; ex_wn = wn; ex_qa = qa; ex_qb = qb; ex_imm = imm;
    ex_wreg = wreg; ex_m2reg = m2reg; ex_wmem = wmem;
    #1;
  endtask

  // Counts stall cycles from the current one until the result edge.
  task automatic run_mul(output int stalls, output int edges);
    stalls = 0;
    edges  = 0;
    while (ex_stall && edges < 200) begin
      stalls++;
      tick();
      edges++;
      if (ex_stall) check("mul_bubble_valid", 32'(mem_valid), 32'd0);
    end
    tick();
    edges++;
  endtask

  int st, ed;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 1'b1};
    vecs[1]  = '{4'd8,  1'b1, 1'b0, 32'h0,        32'h80000000, 32'h4,        32'hF8000000, 1'b0};
    vecs[2]  = '{4'd1,  1'b0, 1'b0, 32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{4'd2,  1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0};
    vecs[4]  = '{4'd3,  1'b0, 1'b0, 32'h0F0F0000, 32'h000000F0, 32'h0,        32'h0F0F00F0, 1'b0};
    vecs[5]  = '{4'd4,  1'b0, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0,        32'h55555555, 1'b0};
    vecs[6]  = '{4'd5,  1'b0, 1'b1, 32'h0,        32'h0,        32'h00001234, 32'h12340000, 1'b0};
    vecs[7]  = '{4'd6,  1'b1, 1'b0, 32'h0,        32'h000000FF, 32'h00000008, 32'h0000FF00, 1'b0};
    vecs[8]  = '{4'd7,  1'b1, 1'b0, 32'h0,        32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vecs[9]  = '{4'd9,  1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 1'b0};
    vecs[10] = '{4'd9,  1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{4'd12, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{4'd0,  1'b0, 1'b1, 32'h00000010, 32'h0,        32'hFFFFFFFF, 32'h0000000F, 1'b0};
    vecs[13] = '{4'd6,  1'b1, 1'b0, 32'h0,        32'h00000003, 32'h00000021, 32'h00000006, 1'b0};

    clrn = 1'b0;
    wb_wreg = 1'b0; wb_wn = '0; wb_data = '0;
    drive(4'd10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8, 32'h3, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stall_forced_low_in_reset", 32'(ex_stall), 32'd0);
    tick(); tick();
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_mem_alu", mem_alu, 32'd0);
    clrn = 1'b1;

    // ALU table: no forwarding because rs/rt never match the previous wn.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].aluc, vecs[i].shift, vecs[i].aluimm, 5'd1, 5'd2, 5'd9,
            vecs[i].qa, vecs[i].qb, vecs[i].imm, 1'b1, 1'b0, 1'b0);
      check($sformatf("vec%0d_stall", i), 32'(ex_stall), 32'd0);
      tick();
      check($sformatf("vec%0d_alu", i), mem_alu, vecs[i].exp_alu);
      check($sformatf("vec%0d_z", i), 32'(mem_z), 32'(vecs[i].exp_z));
      check($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'd1);
    end

    // MEM forwarding: r3 = 5+7, then r4 = r3 - r3 with stale register values.
    drive(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_add_r3", mem_alu, 32'd12);
    drive(4'd1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4, 32'd99, 32'd1, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_mem_sub", mem_alu, 32'd0);
    check("fwd_mem_sub_z", 32'(mem_z), 32'd1);

    // MEM beats WB for the same register.
    drive(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd20, 32'd1, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    wb_wreg = 1'b1; wb_wn = 5'd3; wb_data = 32'd100;
    drive(4'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd7, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_mem_over_wb", mem_alu, 32'd21);

    // WB targeting r0 is ignored.
    wb_wn = 5'd0;
    drive(4'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 32'd4, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_wb_r0_ignored", mem_alu, 32'd9);

    // WB-only forwarding.
    wb_wn = 5'd9; wb_data = 32'h40;
    drive(4'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd8, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_wb_only", mem_alu, 32'h42);
    wb_wreg = 1'b0;

    // Load-use: lw r5 then add r6 = r5 + r1.
    drive(4'd0, 1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0);
    tick();
    check("lw_m2reg", 32'(mem_m2reg), 32'd1);
    check("lw_addr", mem_alu, 32'h104);
    drive(4'd0, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 32'h77, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    check("lu_stall_on", 32'(ex_stall), 32'd1);
    tick();
    check("lu_bubble", 32'(mem_valid), 32'd0);
    wb_wreg = 1'b1; wb_wn = 5'd5; wb_data = 32'h10;
    #1;
    check("lu_stall_one_cycle", 32'(ex_stall), 32'd0);
    tick();
    check("lu_wb_fwd", mem_alu, 32'h12);
    check("lu_valid", 32'(mem_valid), 32'd1);
    wb_wreg = 1'b0;

    // Shift instruction does not read rs, so a load to rs causes no stall.
    drive(4'd0, 1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'd6, 1'b1, 1'b0, 5'd5, 5'd2, 5'd6, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    check("lu_shift_no_stall", 32'(ex_stall), 32'd0);
    tick();
    check("lu_shift_result", mem_alu, 32'h4);

    // Multiply 0x0000FFFF * 0x00010001.
    drive(4'd10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8, 32'h0000FFFF, 32'h00010001, 32'h0, 1'b1, 1'b0, 1'b0);
    run_mul(st, ed);
    check("mul_stall_cycles", 32'(st), 32'd33);
    check("mul_edges", 32'(ed), 32'd34);
    check("mul_result", mem_alu, 32'hFFFFFFFF);
    check("mul_valid", 32'(mem_valid), 32'd1);
    check("mul_wn", 32'(mem_wn), 32'd8);

    // Store reading the multiply destination gets the MEM value.
    drive(4'd0, 1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 32'h0, 32'h5, 32'h20, 1'b0, 1'b0, 1'b1);
    check("sw_no_stall", 32'(ex_stall), 32'd0);
    tick();
    check("sw_di_fwd", mem_di, 32'hFFFFFFFF);
    check("sw_addr", mem_alu, 32'h20);
    check("sw_wmem", 32'(mem_wmem), 32'd1);

    // Invalid multiply is a plain bubble.
    drive(4'd10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8, 32'h3, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    #1;
    check("inv_mul_no_stall", 32'(ex_stall), 32'd0);
    tick();
    check("inv_bubble", 32'(mem_valid), 32'd0);

    // Hazard and multiply together: one load stall, then the full multiply.
    drive(4'd0, 1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h300, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'd10, 1'b0, 1'b0, 5'd5, 5'd2, 5'd11, 32'h77, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0);
    check("hz_mul_stall", 32'(ex_stall), 32'd1);
    tick();
    check("hz_mul_bubble", 32'(mem_valid), 32'd0);
    wb_wreg = 1'b1; wb_wn = 5'd5; wb_data = 32'd3;
    #1;
    run_mul(st, ed);
    check("hz_mul_stall_cycles", 32'(st), 32'd33);
    check("hz_mul_result", mem_alu, 32'd15);
    check("hz_mul_wn", 32'(mem_wn), 32'd11);
    wb_wreg = 1'b0;

    // Reset in the middle of a multiply discards it.
    drive(4'd10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8, 32'h3, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("mid_mul_stalling", 32'(ex_stall), 32'd1);
    clrn = 1'b0;
    #1;
    check("rst_stall_low", 32'(ex_stall), 32'd0);
    tick(); tick();
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_wn", 32'(mem_wn), 32'd0);
    check("rst_mem_di", mem_di, 32'd0);
    check("rst_mem_wreg", 32'(mem_wreg), 32'd0);
    drive(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd3, 32'd4, 32'h0, 1'b1, 1'b0, 1'b0);
    clrn = 1'b1;
    #1;
    check("post_rst_no_stall", 32'(ex_stall), 32'd0);
    tick();
    check("post_rst_add", mem_alu, 32'd7);
    check("post_rst_valid", 32'(mem_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
